// File: rtl/branch_history_table_pkg.sv
// Shared constants, FSM encoding and mispredict helper for the branch history table.
package branch_history_table_pkg;

  localparam int         WORD_W       = 32;
  localparam int         BHT_IDX_W    = 8;
  localparam logic [1:0] BHT_INIT_CNT = 2'b01;

  // Table controller state: INIT sweeps every entry to the initial value, RUN serves reads/updates.
  typedef enum logic {
    BHT_INIT = 1'b0,
    BHT_RUN  = 1'b1
  } bht_state_e;

  // A resolved branch was mispredicted if the direction was wrong, or if it was correctly
  // predicted taken but the target carried down the pipe differs from the resolved one.
  function automatic logic bht_mispredict(
    input logic              pred,
    input logic              taken,
    input logic [WORD_W-1:0] pre_pc,
    input logic [WORD_W-1:0] target
  );
    return (pred != taken) | (pred & taken & (pre_pc != target));
  endfunction

endpackage

// File: rtl/branch_history_table_sat_cnt2.sv
// 2-bit saturating counter step: increment on taken, decrement on not taken, clamp at 0 and 3.
module sat_cnt2 (
  input  logic [1:0] i_cnt,
  input  logic       i_taken,
  output logic [1:0] o_cnt
);

  // Next counter value, clamped at both ends.
  always_comb begin
    o_cnt = i_cnt;
    if (i_taken) begin
      if (i_cnt != 2'b11) o_cnt = i_cnt + 2'b01;
    end else begin
      if (i_cnt != 2'b00) o_cnt = i_cnt - 2'b01;
    end
  end

endmodule

// File: rtl/branch_history_table.sv
// Branch history table: 2-bit counters indexed by pc[IDX_W+1:2], registered prediction for IF,
// counter update and mispredict flush/redirect from EX, plus resolved/mispredict statistics.
//
// Interface timing: rd_valid qualifies rd_pc for one cycle with no back-pressure; predict is
// registered and answers the previous accepted read, holding when rd_valid=0. ex_valid&ex_is_br
// qualifies one resolved branch per cycle; flush is a one-cycle registered pulse the cycle after,
// and redirect_pc is meaningful only while flush=1. busy=1 means reads and updates are ignored.
module branch_history_table
  import branch_history_table_pkg::*;
#(
  parameter int         IDX_W    = BHT_IDX_W,
  parameter logic [1:0] INIT_CNT = BHT_INIT_CNT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rd_valid,
  input  logic [31:0] rd_pc,
  output logic        predict,
  output logic        busy,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred,
  input  logic [31:0] ex_pre_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt,
  output logic        dbg_state
);

  localparam int DEPTH = 1 << IDX_W;

  bht_state_e       r_state;
  logic [IDX_W-1:0] r_init_idx;
  logic [1:0]       r_table [DEPTH];
  logic             r_predict;
  logic             r_flush;
  logic [31:0]      r_redirect_pc;
  logic [31:0]      r_br_cnt;
  logic [31:0]      r_miss_cnt;

  logic             w_run;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic [1:0]       w_cur_cnt;
  logic [1:0]       w_new_cnt;
  logic             w_upd;
  logic             w_miss;
  logic             w_bypass;
  logic             w_unused_pc;

  assign w_run     = (r_state == BHT_RUN);
  assign w_rd_idx  = rd_pc[IDX_W+1:2];
  assign w_ex_idx  = ex_pc[IDX_W+1:2];
  assign w_cur_cnt = r_table[w_ex_idx];
  assign w_upd     = ex_valid & ex_is_br & w_run;
  assign w_miss    = w_upd & bht_mispredict(ex_pred, ex_taken, ex_pre_pc, ex_target);
  // A read hitting the entry being updated this cycle must see the new value.
  assign w_bypass  = w_upd & (w_ex_idx == w_rd_idx);

  // Only the index bits of the fetch PC matter here.
  assign w_unused_pc = ^{rd_pc[31:IDX_W+2], rd_pc[1:0]};

  sat_cnt2 u_sat_cnt2 (
    .i_cnt   (w_cur_cnt),
    .i_taken (ex_taken),
    .o_cnt   (w_new_cnt)
  );

  // Controller FSM: sweep all entries after reset, then stay in RUN until the next reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= BHT_INIT;
      r_init_idx <= '0;
    end else begin
      case (r_state)
        BHT_INIT: begin
          r_init_idx <= r_init_idx + 1'b1;
          if (&r_init_idx) r_state <= BHT_RUN;
        end
        BHT_RUN: r_state <= BHT_RUN;
        default: r_state <= BHT_INIT;
      endcase
    end
  end

  // Single write port: init sweep value during INIT, saturating update during RUN.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (!w_run) begin
        r_table[r_init_idx] <= INIT_CNT;
      end else if (w_upd) begin
        r_table[w_ex_idx] <= w_new_cnt;
      end
    end
  end

  // Prediction register: counter MSB of the accepted fetch PC, forced low while sweeping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_predict <= 1'b0;
    end else if (!w_run) begin
      r_predict <= 1'b0;
    end else if (rd_valid) begin
      r_predict <= w_bypass ? w_new_cnt[1] : r_table[w_rd_idx][1];
    end
  end

  // Mispredict flush pulse, redirect target and saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_br_cnt      <= '0;
      r_miss_cnt    <= '0;
    end else begin
      r_flush <= w_miss;
      if (w_miss) begin
        r_redirect_pc <= ex_taken ? ex_target : (ex_pc + 32'd4);
      end
      if (w_upd && (r_br_cnt != 32'hFFFF_FFFF)) begin
        r_br_cnt <= r_br_cnt + 32'd1;
      end
      if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign predict     = r_predict;
  assign busy        = ~w_run;
  assign flush       = r_flush;
  assign redirect_pc = r_redirect_pc;
  assign br_cnt      = r_br_cnt;
  assign miss_cnt    = r_miss_cnt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table: expected predict and flush/redirect values are queued
// when stimulus is driven and popped by a monitor when the DUT answers.
module tb_branch_history_table;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic        predict;
  logic        busy;
  logic        ex_valid;
  logic        ex_is_br;
  logic [31:0] ex_pc;
  logic        ex_pred;
  logic [31:0] ex_pre_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;
  logic        dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  logic [0:0]  exp_pred_q[$];
  logic [32:0] exp_ex_q[$];

  logic rd_fire = 1'b0;
  logic ex_fire = 1'b0;

  branch_history_table dut (
    .clk         (clk),
    .rstn        (rstn),
    .rd_valid    (rd_valid),
    .rd_pc       (rd_pc),
    .predict     (predict),
    .busy        (busy),
    .ex_valid    (ex_valid),
    .ex_is_br    (ex_is_br),
    .ex_pc       (ex_pc),
    .ex_pred     (ex_pred),
    .ex_pre_pc   (ex_pre_pc),
    .ex_taken    (ex_taken),
    .ex_target   (ex_target),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .br_cnt      (br_cnt),
    .miss_cnt    (miss_cnt),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Monitor: note which requests the DUT accepted at the edge, check its answers half a cycle later
  always @(posedge clk) begin
    rd_fire <= rd_valid & rstn;
    ex_fire <= ex_valid & ex_is_br & rstn;
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (rd_fire) begin
      if (exp_pred_q.size() == 0) chk("pred_q_underflow", 1, 0);
      else chk("predict", {31'd0, predict}, {31'd0, exp_pred_q.pop_front()});
    end
    if (ex_fire) begin
      if (exp_ex_q.size() == 0) chk("ex_q_underflow", 1, 0);
      else begin
        e = exp_ex_q.pop_front();
        chk("flush", {31'd0, flush}, {31'd0, e[32]});
        if (e[32]) chk("redirect_pc", redirect_pc, e[31:0]);
      end
    end else if (flush) begin
      chk("unexpected_flush", {31'd0, flush}, 0);
    end
  end

  // Driver tasks
  task automatic idle();
    rd_valid  = 1'b0;
    rd_pc     = '0;
    ex_valid  = 1'b0;
    ex_is_br  = 1'b0;
    ex_pc     = '0;
    ex_pred   = 1'b0;
    ex_pre_pc = '0;
    ex_taken  = 1'b0;
    ex_target = '0;
  endtask

  // One cycle of stimulus, driven right after a negedge; returns at the next negedge.
  task automatic cycle(
    input logic rv, input logic [31:0] rpc, input logic xpred_out,
    input logic ev, input logic ebr, input logic [31:0] epc, input logic epred,
    input logic [31:0] epre, input logic etaken, input logic [31:0] etgt,
    input logic xflush, input logic [31:0] xredir
  );
    rd_valid  = rv;
    rd_pc     = rpc;
    ex_valid  = ev;
    ex_is_br  = ebr;
    ex_pc     = epc;
    ex_pred   = epred;
    ex_pre_pc = epre;
    ex_taken  = etaken;
    ex_target = etgt;
    if (rv) exp_pred_q.push_back(xpred_out);
    if (ev && ebr) exp_ex_q.push_back({xflush, xredir});
    @(negedge clk);
    idle();
  endtask

  task automatic br(input logic [31:0] pc, input logic pred, input logic [31:0] pre,
                    input logic taken, input logic [31:0] tgt,
                    input logic xflush, input logic [31:0] xredir);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, pc, pred, pre, taken, tgt, xflush, xredir);
  endtask

  task automatic rd(input logic [31:0] pc, input logic xp);
    cycle(1'b1, pc, xp, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // Release reset and hammer reads/mispredicting updates while busy; all must be ignored.
  task automatic run_sweep();
    int count;
    count = 0;
    rstn = 1'b1;
    while (busy && count < 1000) begin
      count++;
      rd_valid  = 1'b1;
      rd_pc     = $urandom_range(0, 32'h0000_FFFF) << 2;
      ex_valid  = 1'b1;
      ex_is_br  = 1'b1;
      ex_pc     = rd_pc;
      ex_pred   = 1'b0;
      ex_pre_pc = 32'd0;
      ex_taken  = 1'b1;
      ex_target = 32'h1C00_0F00;
      exp_pred_q.push_back(1'b0);
      exp_ex_q.push_back({1'b0, 32'd0});
      @(negedge clk);
    end
    idle();
    chk("init_busy_cycles", count, 256);
    chk("run_state", {31'd0, dbg_state}, 1);
  endtask

  localparam logic [31:0] PC_A = 32'h1C00_0010;
  localparam logic [31:0] TG_A = 32'h1C00_0080;
  localparam logic [31:0] PC_B = 32'h1C00_0040;
  localparam logic [31:0] PC_W = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_C = 32'h1C00_0300;

  initial begin
    idle();
    rstn = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", {31'd0, busy}, 1);
    chk("rst_state", {31'd0, dbg_state}, 0);
    chk("rst_predict", {31'd0, predict}, 0);
    chk("rst_flush", {31'd0, flush}, 0);
    chk("rst_br_cnt", br_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_redirect", redirect_pc, 0);

    run_sweep();

    // Taken training at PC_A: 01->10->11->11, then one not-taken leaves 10
    br(PC_A, 1'b0, 32'd0, 1'b1, TG_A, 1'b1, TG_A);
    chk("br_cnt_first", br_cnt, 1);
    chk("miss_cnt_first", miss_cnt, 1);
    br(PC_A, 1'b1, TG_A, 1'b1, TG_A, 1'b0, 32'd0);
    br(PC_A, 1'b1, TG_A, 1'b1, TG_A, 1'b0, 32'd0);
    rd(PC_A, 1'b1);
    br(PC_A, 1'b1, TG_A, 1'b0, TG_A, 1'b1, 32'h1C00_0014);
    rd(PC_A, 1'b1);
    rd(32'h1C00_0020, 1'b0);

    // Correct direction, wrong target; then matching target
    br(PC_B, 1'b1, 32'h1C00_0100, 1'b1, 32'h1C00_0200, 1'b1, 32'h1C00_0200);
    br(PC_B, 1'b1, 32'h1C00_0200, 1'b1, 32'h1C00_0200, 1'b0, 32'd0);

    // Not-taken mispredict at top of address space: pc+4 wraps to 0; counter 01->00
    br(PC_W, 1'b1, 32'h1C00_0500, 1'b0, 32'h1C00_0500, 1'b1, 32'h0000_0000);
    // Saturate at 00, then taken with same-cycle read: bypass sees 01 -> predict 0
    br(PC_W, 1'b0, 32'd0, 1'b0, 32'h1C00_0500, 1'b0, 32'd0);
    cycle(1'b1, PC_W, 1'b0, 1'b1, 1'b1, PC_W, 1'b0, 32'd0, 1'b1, 32'h1C00_0600, 1'b1, 32'h1C00_0600);
    rd(PC_W, 1'b0);
    br(PC_W, 1'b1, 32'h1C00_0600, 1'b1, 32'h1C00_0600, 1'b0, 32'd0);
    rd(PC_W, 1'b1);

    // Back-to-back mispredicts give two flush pulses with their own redirects
    br(32'h1C00_0400, 1'b0, 32'd0, 1'b1, 32'h1C00_0A00, 1'b1, 32'h1C00_0A00);
    br(32'h1C00_0404, 1'b1, 32'h1C00_0B00, 1'b0, 32'h1C00_0B00, 1'b1, 32'h1C00_0408);

    // Same-index read and taken update at cnt=01: bypass gives predict 1
    cycle(1'b1, PC_C, 1'b1, 1'b1, 1'b1, PC_C, 1'b0, 32'd0, 1'b1, 32'h1C00_0700, 1'b1, 32'h1C00_0700);

    // Non-branch or invalid EX slots are ignored even with mismatched prediction fields
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, PC_C, 1'b0, 32'd0, 1'b1, 32'h1C00_0800, 1'b0, 32'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, PC_C, 1'b0, 32'd0, 1'b1, 32'h1C00_0800, 1'b0, 32'd0);
    @(negedge clk);
    chk("br_cnt_total", br_cnt, 13);
    chk("miss_cnt_total", miss_cnt, 8);

    // Reset during RUN with a mispredicting update and a read in flight
    rstn = 1'b0;
    rd_valid = 1'b1; rd_pc = PC_A;
    ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = PC_A; ex_pred = 1'b0;
    ex_taken = 1'b1; ex_target = TG_A;
    @(negedge clk);
    idle();
    chk("mid_rst_flush", {31'd0, flush}, 0);
    chk("mid_rst_br_cnt", br_cnt, 0);
    chk("mid_rst_miss_cnt", miss_cnt, 0);
    chk("mid_rst_busy", {31'd0, busy}, 1);
    chk("mid_rst_predict", {31'd0, predict}, 0);

    // Abort a sweep part-way; the next one must still take the full length
    rstn = 1'b1;
    repeat (100) @(negedge clk);
    chk("partial_busy", {31'd0, busy}, 1);
    rstn = 1'b0;
    @(negedge clk);
    run_sweep();

    // Table was re-initialised: PC_A back to weakly not-taken
    rd(PC_A, 1'b0);
    br(PC_A, 1'b0, 32'd0, 1'b1, TG_A, 1'b1, TG_A);
    rd(PC_A, 1'b1);

    repeat (3) @(negedge clk);
    chk("pred_q_drained", exp_pred_q.size(), 0);
    chk("ex_q_drained", exp_ex_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
